serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 217 +++++++++++++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor. It computes difference = a - b - borrowin, modulo
// 2^WIDTH, and works on one bit per clock, LSB first, using a single borrow
// flip-flop.
//
// A request accepted at edge N shows its result with done high in the cycle
// after edge N+WIDTH+1.
//
// Parameters
//   WIDTH       operand and result width in bits (2..32)
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset; deassert synchronously to clk
//   start       request a new subtraction; accepted only while idle
//   a, b        minuend / subtrahend, captured when start is accepted
//   borrowin    borrow into bit 0, captured when start is accepted
//   busy        high while an operation is in SHIFT or DONE
//   done        one-cycle pulse; difference/borrowout are valid with it
//   difference  last completed result, held until the next completion
//   borrowout   borrow out of bit WIDTH-1 of the last result
//   overflow    signed overflow of the last result; this port exists only
//               when SERIAL_SUB_OVERFLOW_EN is defined
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrowout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One full-subtractor bit: difference output.
    function automatic logic sub_diff_bit(input logic ai, input logic bi, input logic bri);
        return ai ^ bi ^ bri;
    endfunction

    // One full-subtractor bit: borrow output.
    function automatic logic sub_borrow_bit(input logic ai, input logic bi, input logic bri);
        return (~ai & bi) | (~(ai ^ bi) & bri);
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  d_r;
    logic              br_r;
    logic              diff_bit_s;
    logic              br_next_s;
    logic              busy_s;
    logic              done_s;
    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  difference_r;
    logic              borrowout_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic              a_msb_r;
    logic              b_msb_r;
    logic              overflow_r;
`endif

    // Current operand bits are always at position 0 of the shifting registers.
    assign diff_bit_s = sub_diff_bit(a_r[0], b_r[0], br_r);
    assign br_next_s  = sub_borrow_bit(a_r[0], b_r[0], br_r);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_SHIFT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode. This is computed from the next state so that the
    // registered busy lines up with SHIFT and DONE.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
        if (next_state_s != ST_IDLE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Datapath: operand capture, the serial shift, and the result load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= {CNT_W{1'b0}};
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            d_r          <= {WIDTH{1'b0}};
            br_r         <= 1'b0;
            difference_r <= {WIDTH{1'b0}};
            borrowout_r  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_r      <= 1'b0;
            b_msb_r      <= 1'b0;
            overflow_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        br_r  <= borrowin;
                        cnt_r <= {CNT_W{1'b0}};
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // The MSBs shift out before DONE, so keep a copy here.
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    // Result bits enter at the top and end up in place after WIDTH shifts.
                    d_r   <= {diff_bit_s, d_r[WIDTH-1:1]};
                    br_r  <= br_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                ST_DONE: begin
                    difference_r <= d_r;
                    borrowout_r  <= br_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    overflow_r   <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_r[WIDTH-1]);
`endif
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign difference = difference_r;
    assign borrowout  = borrowout_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow   = overflow_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed-vector bench for serial_subtractor with WIDTH=8. The expected
// values are worked out by hand. Inputs are driven 1 time unit after a rising
// edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrowin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrowout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    int n_total;
    int n_bad;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrowin   (borrowin),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrowout  (borrowout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Waits, with a cycle bound, until done is high. It returns the number of
    // edges waited and whether busy dropped before done appeared.
    task automatic wait_done(output int cyc, output bit busy_drop);
        cyc = 0;
        busy_drop = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (!busy) busy_drop = 1'b1;
        end
    endtask

    // Counts done pulses over n cycles while start is low.
    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
    endtask

    // Runs one isolated operation and checks the latency, busy, the result
    // and the one-cycle done pulse.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vbin, input logic [7:0] exp_d, input logic exp_bo,
                          input logic exp_ov);
        int cyc;
        bit drop;
        a = va; b = vb; borrowin = vbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va; b = ~vb; borrowin = ~vbin;       // must not disturb the in-flight op
        wait_done(cyc, drop);
        check_val({tag, "_latency"}, cyc, 9);
        check_val({tag, "_busy_gap"}, {31'd0, drop}, 32'd0);
        check_val({tag, "_diff"}, {24'd0, difference}, {24'd0, exp_d});
        check_val({tag, "_borrow"}, {31'd0, borrowout}, {31'd0, exp_bo});
`ifdef SERIAL_SUB_OVERFLOW_EN
        check_val({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ov});
`else
        if (exp_ov === 1'bx) $display("note: unexpected X overflow expectation");
`endif
        @(posedge clk);
        #1;
        check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_val({tag, "_diff_hold"}, {24'd0, difference}, {24'd0, exp_d});
    endtask

    initial begin
        int cyc;
        int pulses;
        bit drop;
        n_total = 0;
        n_bad = 0;
        reset_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        borrowin = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_diff", {24'd0, difference}, 32'd0);
        check_val("rst_borrow", {31'd0, borrowout}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("basic",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("neg",     8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op("bin",     8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("allone",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("pattern", 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0);
        run_op("ovf",     8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("ovf_neg", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // A start pulse while busy must be ignored.
        a = 8'h10; b = 8'h01; borrowin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'h20; b = 8'h02; borrowin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, drop);
        check_val("busy_start_latency", cyc, 6);
        check_val("busy_start_gap", {31'd0, drop}, 32'd0);
        check_val("busy_start_diff", {24'd0, difference}, 32'h0F);
        check_val("busy_start_borrow", {31'd0, borrowout}, 32'd0);
        count_done(14, pulses);
        check_val("busy_start_single_done", pulses, 0);

        // Reset in the middle of SHIFT.
        a = 8'h33; b = 8'h11; borrowin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_diff", {24'd0, difference}, 32'd0);
        check_val("midrst_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_done(14, pulses);
        check_val("midrst_no_done", pulses, 0);
        check_val("midrst_busy_after", {31'd0, busy}, 32'd0);
        run_op("after_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

        // With start held high, operations repeat every WIDTH+2 cycles.
        a = 8'h07; b = 8'h02; borrowin = 1'b0; start = 1'b1;
        wait_done(cyc, drop);
        check_val("b2b_first_latency", cyc, 10);
        check_val("b2b_first_diff", {24'd0, difference}, 32'h05);
        a = 8'h02; b = 8'h07;
        wait_done(cyc, drop);
        start = 1'b0;
        check_val("b2b_period", cyc, 10);
        check_val("b2b_second_diff", {24'd0, difference}, 32'hFB);
        check_val("b2b_second_borrow", {31'd0, borrowout}, 32'd1);
        count_done(14, pulses);
        check_val("b2b_stop", pulses, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
